game_sequencer: RTL

GAME_SEQUENCER -- requirements
Module: game_sequencer

---
 rtl/game_sequencer.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/game_sequencer.sv
// Whack-a-mole game sequencer: runs a timed game, raises one pseudo-random mole at a time
// and counts hits. All outputs come straight from flops.
module game_sequencer #(
  parameter int TICKS_PER_SEC = 100000000,
  parameter int GAME_SECONDS  = 60,
  parameter int MOLE_CYCLES   = 75000000,
  parameter int GAP_CYCLES    = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] hit,
  output logic [3:0] mole,
  output logic [5:0] time_left,
  output logic [7:0] score,
  output logic       sec_tick,
  output logic [1:0] state,
  output logic       game_over
);

  localparam int PW     = $clog2(TICKS_PER_SEC + 1);
  localparam int PH_MAX = (MOLE_CYCLES > GAP_CYCLES) ? MOLE_CYCLES : GAP_CYCLES;
  localparam int CW     = $clog2(PH_MAX + 1);

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(MOLE_CYCLES - 1);
  localparam logic [5:0]    GAME_LEN   = 6'(GAME_SECONDS);
  localparam logic [7:0]    LFSR_SEED  = 8'hA5;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_PLAY = 2'b01,
    S_OVER = 2'b10
  } state_t;

  typedef enum logic {
    PH_GAP  = 1'b0,
    PH_SHOW = 1'b1
  } phase_t;

  state_t          state_q, state_d;
  phase_t          phase_q, phase_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [5:0]      time_left_q, time_left_d;
  logic [7:0]      score_q, score_d;
  logic [3:0]      mole_q, mole_d;
  logic            sec_tick_q, sec_tick_d;
  logic            game_over_q, game_over_d;
  logic [1:0]      prev_hole_q, prev_hole_d;
  logic [7:0]      lfsr_q, lfsr_d;

  logic            tick;
  logic            hit_match;
  logic [1:0]      new_hole;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    presc_d     = presc_q;
    cnt_d       = cnt_q;
    time_left_d = time_left_q;
    score_d     = score_q;
    mole_d      = mole_q;
    sec_tick_d  = 1'b0;
    prev_hole_d = prev_hole_q;
    // x^8+x^6+x^5+x^4+1, free-running in every state
    lfsr_d      = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    tick      = (state_q == S_PLAY) && (presc_q == PRESC_LAST);
    hit_match = (phase_q == PH_SHOW) && (|(hit & mole_q));
    // never raise the same hole twice in a row
    new_hole  = (lfsr_q[1:0] == prev_hole_q) ? lfsr_q[1:0] + 2'd1 : lfsr_q[1:0];

    case (state_q)
      S_PLAY: begin
        presc_d    = tick ? '0 : presc_q + 1'b1;
        sec_tick_d = tick;

        if (phase_q == PH_GAP) begin
          if (cnt_q == GAP_LAST) begin
            phase_d     = PH_SHOW;
            cnt_d       = '0;
            mole_d      = 4'b0001 << new_hole;
            prev_hole_d = new_hole;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (hit_match || (cnt_q == SHOW_LAST)) begin
          phase_d = PH_GAP;
          cnt_d   = '0;
          mole_d  = '0;
          if (hit_match && (score_q != 8'hFF)) begin
            score_d = score_q + 8'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end

        // game expiry overrides the mole phase but keeps a same-cycle score update
        if (tick) begin
          if (time_left_q <= 6'd1) begin
            time_left_d = '0;
            state_d     = S_OVER;
            mole_d      = '0;
            phase_d     = PH_GAP;
            cnt_d       = '0;
          end else begin
            time_left_d = time_left_q - 6'd1;
          end
        end
      end

      S_IDLE, S_OVER: begin
        presc_d = '0;
        mole_d  = '0;
        if (start) begin
          state_d     = S_PLAY;
          time_left_d = GAME_LEN;
          score_d     = '0;
          phase_d     = PH_GAP;
          cnt_d       = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
        presc_d = '0;
        mole_d  = '0;
      end
    endcase

    game_over_d = (state_d == S_OVER);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      phase_q     <= PH_GAP;
      presc_q     <= '0;
      cnt_q       <= '0;
      time_left_q <= GAME_LEN;
      score_q     <= '0;
      mole_q      <= '0;
      sec_tick_q  <= 1'b0;
      game_over_q <= 1'b0;
      prev_hole_q <= '0;
      lfsr_q      <= LFSR_SEED;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      presc_q     <= presc_d;
      cnt_q       <= cnt_d;
      time_left_q <= time_left_d;
      score_q     <= score_d;
      mole_q      <= mole_d;
      sec_tick_q  <= sec_tick_d;
      game_over_q <= game_over_d;
      prev_hole_q <= prev_hole_d;
      lfsr_q      <= lfsr_d;
    end
  end

  assign mole      = mole_q;
  assign time_left = time_left_q;
  assign score     = score_q;
  assign sec_tick  = sec_tick_q;
  assign state     = state_q;
  assign game_over = game_over_q;

endmodule
